// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
// Holds the op encodings, the FSM state type and the default operand width.
package mdu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // op[0] selects the operation
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // bit position of the unsigned select inside op
  localparam int OP_UNSIGNED = 1;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    FINISH
  } state_t;

endpackage

// File: rtl/mdu_sign_adjust.sv
// mdu_sign_adjust: combinational sign handling wrapped around the unsigned
// restoring divider. It produces the operand magnitudes the divider iterates
// on and applies the final fix-up: the quotient is negated when the operand
// signs differ (truncation toward zero) and the remainder takes the sign of
// the dividend. With is_signed low every value passes straight through.
module mdu_sign_adjust
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] quot_raw,
  input  logic [WIDTH-1:0] rem_raw,
  output logic [WIDTH-1:0] a_mag,
  output logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  logic a_neg;
  logic b_neg;

  // Magnitudes and result fix-up. The most negative value negates onto
  // itself, which is exactly its magnitude read as an unsigned number, so the
  // overflow case (min / -1) wraps back to min without any special handling.
  always_comb begin
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    quot  = (a_neg ^ b_neg) ? -quot_raw : quot_raw;
    rem   = a_neg ? -rem_raw : rem_raw;
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit feeding the HI/LO registers.
// A single-cycle start pulse launches a radix-2 Booth multiply or a restoring
// divide, each taking WIDTH steps; a single-cycle done pulse (with div_zero
// for a zero divisor) marks the cycle in which hi/lo are valid.
// Optional build macro: MULT_DIV_UNSIGNED_EN enables multu/divu via op[1];
// without it op[1] is ignored and every operation is signed.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);
  // Booth partial product carries two guard bits so that P +/- M never
  // overflows, even for the most negative multiplicand or an unsigned one.
  localparam int PW = WIDTH + 2;
  localparam int AW = PW + WIDTH + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             signed_op;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-2:0] quot_reg;

  logic             signed_in;
  logic             is_div;

  logic [PW-1:0]    m_ext;
  logic [PW-1:0]    p_cur;
  logic [PW-1:0]    p_sum;
  logic [AW-1:0]    acc_next;
  logic [WIDTH-1:0] mult_hi;

  logic [IW-1:0]    bit_idx;
  logic [WIDTH:0]   partial;
  logic             take;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quot_fixed;
  logic [WIDTH-1:0] rem_fixed;

`ifdef MULT_DIV_UNSIGNED_EN
  assign signed_in = ~op[OP_UNSIGNED];
`else
  logic unused_op_bit;
  assign signed_in     = 1'b1;
  assign unused_op_bit = op[OP_UNSIGNED];
`endif

  assign is_div = (op[0] == OP_DIV);

  mdu_sign_adjust #(
    .WIDTH(WIDTH)
  ) u_sign_adjust (
    .is_signed(signed_op),
    .a        (a_reg),
    .b        (b_reg),
    .quot_raw (quot_next),
    .rem_raw  (rem_next),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .quot     (quot_fixed),
    .rem      (rem_fixed)
  );

  // One Booth step: inspect {q0, q-1}, add or subtract the multiplicand into
  // P, then arithmetic-shift the whole {P, Q, q-1} accumulator right by one.
  // Booth treats the multiplier as signed, so an unsigned multiplier with its
  // top bit set is repaired by adding the multiplicand into the upper half.
  always_comb begin
    m_ext    = signed_op ? {{2{a_reg[WIDTH-1]}}, a_reg} : {2'b00, a_reg};
    p_cur    = acc[AW-1:WIDTH+1];
    case (acc[1:0])
      2'b01:   p_sum = p_cur + m_ext;
      2'b10:   p_sum = p_cur - m_ext;
      default: p_sum = p_cur;
    endcase
    acc_next = {p_sum[PW-1], p_sum, acc[WIDTH:1]};
    mult_hi  = acc_next[2*WIDTH:WIDTH+1];
`ifdef MULT_DIV_UNSIGNED_EN
    if (!signed_op && b_reg[WIDTH-1]) begin
      mult_hi = mult_hi + a_reg;
    end
`endif
  end

  // One restoring-division step: bring down the next dividend magnitude bit
  // (MSB first), subtract the divisor magnitude if it fits and shift the
  // resulting quotient bit in.
  always_comb begin
    bit_idx   = IW'(WIDTH - 1) - counter[IW-1:0];
    partial   = {rem_reg, a_mag[bit_idx]};
    take      = (partial >= {1'b0, b_mag});
    rem_next  = take ? (partial[WIDTH-1:0] - b_mag) : partial[WIDTH-1:0];
    quot_next = {quot_reg, take};
  end

  // Control FSM with registered busy/done/div_zero and the HI/LO results.
  // IDLE and FINISH accept requests; MULT and DIV ignore start until their
  // terminal step, then load hi/lo and enter FINISH for exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      signed_op <= 1'b0;
      acc       <= '0;
      rem_reg   <= '0;
      quot_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE, FINISH: begin
          busy <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            signed_op <= signed_in;
            counter   <= '0;
            if (!is_div) begin
              state <= MULT;
              busy  <= 1'b1;
              acc   <= {{PW{1'b0}}, b, 1'b0};
            end else if (b != '0) begin
              state    <= DIV;
              busy     <= 1'b1;
              rem_reg  <= '0;
              quot_reg <= '0;
            end else begin
              state    <= FINISH;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        MULT: begin
          acc <= acc_next;
          if (counter == LAST_STEP) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= mult_hi;
            lo    <= acc_next[WIDTH:1];
          end else begin
            counter <= counter + CW'(1);
          end
        end
        DIV: begin
          rem_reg  <= rem_next;
          quot_reg <= quot_next[WIDTH-2:0];
          if (counter == LAST_STEP) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= rem_fixed;
            lo    <= quot_fixed;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
